// File: rtl/and_32.sv
// Bitwise AND unit for the ALU: combinational result plus a registered copy
// carrying valid, zero and set-bit-count flags for the pipelined result path.
module and_32 #(
    parameter int WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           Ra,
    input  logic [WIDTH-1:0]           Rb,
    input  logic                       en,
    output logic [WIDTH-1:0]           Rz,
    output logic [WIDTH-1:0]           Rz_q,
    output logic                       valid_q,
    output logic                       zero_q,
    output logic [$clog2(WIDTH):0]     ones_q
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] w_and;
    logic [CW-1:0]    w_ones;
    logic             w_zero;

    logic [WIDTH-1:0] r_rz;
    logic             r_valid;
    logic             r_zero;
    logic [CW-1:0]    r_ones;

    assign w_and  = Ra & Rb;
    assign w_zero = (w_and == '0);

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ones = w_ones + CW'(w_and[i]);
        end
    end

    // Flags hold with the result when en is low; only valid drops.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_rz    <= '0;
            r_valid <= 1'b0;
            r_zero  <= 1'b1;
            r_ones  <= '0;
        end else begin
            r_valid <= en;
            if (en) begin
                r_rz   <= w_and;
                r_zero <= w_zero;
                r_ones <= w_ones;
            end
        end
    end

    assign Rz      = w_and;
    assign Rz_q    = r_rz;
    assign valid_q = r_valid;
    assign zero_q  = r_zero;
    assign ones_q  = r_ones;

endmodule

// File: tb/tb_and_32.sv
// Directed-vector bench for and_32: combinational result, capture flags,
// hold behaviour, back-to-back captures and asynchronous clear.
module tb_and_32;

    logic        clock;
    logic        clear;
    logic [31:0] Ra;
    logic [31:0] Rb;
    logic        en;
    logic [31:0] Rz;
    logic [31:0] Rz_q;
    logic        valid_q;
    logic        zero_q;
    logic [5:0]  ones_q;

    int checks = 0;
    int errors = 0;

    and_32 #(.WIDTH(32)) dut (
        .clock   (clock),
        .clear   (clear),
        .Ra      (Ra),
        .Rb      (Rb),
        .en      (en),
        .Rz      (Rz),
        .Rz_q    (Rz_q),
        .valid_q (valid_q),
        .zero_q  (zero_q),
        .ones_q  (ones_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after the rising edge, outputs sampled there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1; en = 1'b0; Ra = 32'hDEADBEEF; Rb = 32'hFFFFFFFF;
        #3;
        checks++; if (Rz_q !== 32'h0) begin errors++; $display("FAIL reset_rz_q: got %h expected %h", Rz_q, 32'h0); end
        checks++; if (valid_q !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected %b", valid_q, 1'b0); end
        checks++; if (zero_q !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected %b", zero_q, 1'b1); end
        checks++; if (ones_q !== 6'd0) begin errors++; $display("FAIL reset_ones: got %0d expected %0d", ones_q, 0); end
        checks++; if (Rz !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_rz_comb: got %h expected %h", Rz, 32'hDEADBEEF); end
        tick();
        checks++; if (Rz_q !== 32'h0) begin errors++; $display("FAIL reset_edge_rz_q: got %h expected %h", Rz_q, 32'h0); end
        @(negedge clock);
        clear = 1'b0;
        tick();
    endtask

    task automatic test_capture(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_rz, input logic [5:0] exp_ones,
                                input logic exp_zero, input string name);
        Ra = a; Rb = b; en = 1'b1;
        #1;
        checks++; if (Rz !== exp_rz) begin errors++; $display("FAIL %s_rz: got %h expected %h", name, Rz, exp_rz); end
        tick();
        en = 1'b0;
        checks++; if (Rz_q !== exp_rz) begin errors++; $display("FAIL %s_rz_q: got %h expected %h", name, Rz_q, exp_rz); end
        checks++; if (ones_q !== exp_ones) begin errors++; $display("FAIL %s_ones: got %0d expected %0d", name, ones_q, exp_ones); end
        checks++; if (zero_q !== exp_zero) begin errors++; $display("FAIL %s_zero: got %b expected %b", name, zero_q, exp_zero); end
        checks++; if (valid_q !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b expected %b", name, valid_q, 1'b1); end
        tick();
        checks++; if (valid_q !== 1'b0) begin errors++; $display("FAIL %s_valid_drop: got %b expected %b", name, valid_q, 1'b0); end
    endtask

    task automatic test_comb();
        Ra = 32'hFFFFFFFF; Rb = 32'h00000000; en = 1'b0;
        #1;
        checks++; if (Rz !== 32'h00000000) begin errors++; $display("FAIL comb_ff_00: got %h expected %h", Rz, 32'h0); end
        Ra = 32'hF0F0F0F0; Rb = 32'hFF00FF00;
        #1;
        checks++; if (Rz !== 32'hF000F000) begin errors++; $display("FAIL comb_f0_ff00: got %h expected %h", Rz, 32'hF000F000); end
    endtask

    task automatic test_hold();
        logic [31:0] a_v [3];
        logic [31:0] b_v [3];
        logic [31:0] r_v [3];
        int valid_cycles;
        a_v = '{32'h0000FFFF, 32'h12345678, 32'hFFFFFFFF};
        b_v = '{32'hFFFFFFFF, 32'h87654321, 32'h0000000F};
        r_v = '{32'h0000FFFF, 32'h02244220, 32'h0000000F};
        Ra = 32'hFFFFFFFF; Rb = 32'hFFFFFFFF; en = 1'b1;
        tick();
        en = 1'b0;
        valid_cycles = (valid_q === 1'b1) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            Ra = a_v[i]; Rb = b_v[i];
            #1;
            checks++; if (Rz !== r_v[i]) begin errors++; $display("FAIL hold_rz_track%0d: got %h expected %h", i, Rz, r_v[i]); end
            tick();
            if (valid_q === 1'b1) valid_cycles++;
            checks++; if (Rz_q !== 32'hFFFFFFFF) begin errors++; $display("FAIL hold_rz_q%0d: got %h expected %h", i, Rz_q, 32'hFFFFFFFF); end
            checks++; if (ones_q !== 6'd32) begin errors++; $display("FAIL hold_ones%0d: got %0d expected %0d", i, ones_q, 32); end
        end
        checks++; if (valid_cycles != 1) begin errors++; $display("FAIL hold_valid_pulse: got %0d cycles expected %0d", valid_cycles, 1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_v [3];
        logic [31:0] b_v [3];
        logic [31:0] r_v [3];
        logic [5:0]  n_v [3];
        a_v = '{32'h00000001, 32'hAAAAAAAA, 32'h80000000};
        b_v = '{32'h00000003, 32'h55555555, 32'hC0000001};
        r_v = '{32'h00000001, 32'h00000000, 32'h80000000};
        n_v = '{6'd1, 6'd0, 6'd1};
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Ra = a_v[i]; Rb = b_v[i];
            tick();
            checks++; if (Rz_q !== r_v[i]) begin errors++; $display("FAIL b2b_rz_q%0d: got %h expected %h", i, Rz_q, r_v[i]); end
            checks++; if (ones_q !== n_v[i]) begin errors++; $display("FAIL b2b_ones%0d: got %0d expected %0d", i, ones_q, n_v[i]); end
            checks++; if (zero_q !== (r_v[i] == 32'h0)) begin errors++; $display("FAIL b2b_zero%0d: got %b expected %b", i, zero_q, (r_v[i] == 32'h0)); end
            checks++; if (valid_q !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %b expected %b", i, valid_q, 1'b1); end
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        Ra = 32'h0F0F0F0F; Rb = 32'hFFFFFFFF; en = 1'b1;
        tick();
        en = 1'b0;
        #2;
        clear = 1'b1;
        #1;
        checks++; if (Rz_q !== 32'h0) begin errors++; $display("FAIL clr_async_rz_q: got %h expected %h", Rz_q, 32'h0); end
        checks++; if (ones_q !== 6'd0) begin errors++; $display("FAIL clr_async_ones: got %0d expected %0d", ones_q, 0); end
        checks++; if (zero_q !== 1'b1) begin errors++; $display("FAIL clr_async_zero: got %b expected %b", zero_q, 1'b1); end
        checks++; if (valid_q !== 1'b0) begin errors++; $display("FAIL clr_async_valid: got %b expected %b", valid_q, 1'b0); end
        checks++; if (Rz !== 32'h0F0F0F0F) begin errors++; $display("FAIL clr_rz_comb: got %h expected %h", Rz, 32'h0F0F0F0F); end
        en = 1'b1;
        tick();
        checks++; if (Rz_q !== 32'h0) begin errors++; $display("FAIL clr_en_rz_q: got %h expected %h", Rz_q, 32'h0); end
        checks++; if (valid_q !== 1'b0) begin errors++; $display("FAIL clr_en_valid: got %b expected %b", valid_q, 1'b0); end
        @(negedge clock);
        clear = 1'b0;
        tick();
        en = 1'b0;
        checks++; if (Rz_q !== 32'h0F0F0F0F) begin errors++; $display("FAIL clr_release_rz_q: got %h expected %h", Rz_q, 32'h0F0F0F0F); end
        checks++; if (ones_q !== 6'd16) begin errors++; $display("FAIL clr_release_ones: got %0d expected %0d", ones_q, 16); end
        tick();
    endtask

    initial begin
        test_reset();
        test_capture(32'h00000000, 32'h00000000, 32'h00000000, 6'd0, 1'b1, "zero");
        test_comb();
        test_capture(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd32, 1'b0, "ones");
        test_capture(32'hAAAAAAAA, 32'h55555555, 32'h00000000, 6'd0, 1'b1, "alt");
        test_capture(32'h12345678, 32'h87654321, 32'h02244220, 6'd6, 1'b0, "mixed");
        test_hold();
        test_back_to_back();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
